// File: rtl/ddr2_arbiter_pkg.sv
// Shared DDR2 command encodings, default geometry and arbiter state encoding.
// Pure declarations; no logic and no timing of its own.
package ddr2_arbiter_pkg;

    localparam int DDR2_BA_BITS   = 3;
    localparam int DDR2_ADDR_BITS = 14;
    localparam int DDR2_TCK_PS    = 2500;
    localparam int DDR2_TREFI_NS  = 7800;
    localparam int DDR2_TREFI_CYC = DDR2_TREFI_NS * 1000 / DDR2_TCK_PS;
    localparam int DDR2_MAX_PEND  = 8;

    // {cs_n, ras_n, cas_n, we_n}
    typedef logic [3:0] cmd_t;
    localparam cmd_t CMD_NOP  = 4'b0111;
    localparam cmd_t CMD_PRE  = 4'b0010;
    localparam cmd_t CMD_AREF = 4'b0001;
    localparam cmd_t CMD_LM   = 4'b0000;
    localparam cmd_t CMD_ACT  = 4'b0011;
    localparam cmd_t CMD_WR   = 4'b0100;
    localparam cmd_t CMD_RD   = 4'b0101;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/ddr2_ref_timer.sv
// tREFI interval timer plus postponed-refresh counter with sticky saturation flag.
// Pending count updates one cycle after expiry/aref_end; no backpressure, aref_end is a pulse.
module ddr2_ref_timer #(
    parameter int TREFI_CYC = 3120,
    parameter int MAX_PEND  = 8
) (
    input  logic ck,
    input  logic rst_n,
    input  logic en_i,
    input  logic aref_end_i,
    output logic ref_pending_o,
    output logic ref_overflow_o
);

    localparam int TW = $clog2(TREFI_CYC);
    localparam int PW = $clog2(MAX_PEND) + 1;

    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          expiry;

    assign expiry = en_i && (timer_q == TW'(TREFI_CYC - 1));

    always_comb begin
        timer_d = timer_q;
        if (en_i) begin
            timer_d = expiry ? '0 : timer_q + TW'(1);
        end
    end

    // Simultaneous expiry and completion cancel out; a lost refresh only latches overflow.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (expiry && !aref_end_i) begin
            if (pend_q == PW'(MAX_PEND)) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PW'(1);
            end
        end else if (aref_end_i && !expiry && (pend_q != '0)) begin
            pend_d = pend_q - PW'(1);
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ref_pending_o  = (pend_q != '0);
    assign ref_overflow_o = ovf_q;

endmodule

// File: rtl/ddr2_arbiter.sv
// DDR2 command-bus owner: init pass-through, then refresh > write/read round-robin grants.
// Bus registered one cycle after the owning source; grants held until the owner's *_end pulse.
module ddr2_arbiter
    import ddr2_arbiter_pkg::*;
#(
    parameter int BA_BITS   = DDR2_BA_BITS,
    parameter int ADDR_BITS = DDR2_ADDR_BITS,
    parameter int TREFI_CYC = DDR2_TREFI_CYC,
    parameter int MAX_PEND  = DDR2_MAX_PEND
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic                 init_end,
    input  logic                 init_cke,
    input  logic [BA_BITS-1:0]   init_ba,
    input  logic [3:0]           init_cmd,
    input  logic [ADDR_BITS-1:0] init_addr,
    output logic                 aref_en,
    input  logic                 aref_end,
    input  logic [3:0]           aref_cmd,
    input  logic [BA_BITS-1:0]   aref_ba,
    input  logic [ADDR_BITS-1:0] aref_addr,
    input  logic                 wr_req,
    output logic                 wr_en,
    input  logic                 wr_end,
    input  logic [3:0]           wr_cmd,
    input  logic [BA_BITS-1:0]   wr_ba,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic                 rd_req,
    output logic                 rd_en,
    input  logic                 rd_end,
    input  logic [3:0]           rd_cmd,
    input  logic [BA_BITS-1:0]   rd_ba,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 ddr2_cke,
    output logic [3:0]           ddr2_cmd,
    output logic [BA_BITS-1:0]   ddr2_ba,
    output logic [ADDR_BITS-1:0] ddr2_addr,
    output logic                 ref_overflow
);

    arb_state_e           state_q, state_d;
    logic                 last_wr_q, last_wr_d;
    logic                 ref_pending;
    logic                 cke_d;
    logic [3:0]           cmd_d;
    logic [BA_BITS-1:0]   ba_d;
    logic [ADDR_BITS-1:0] addr_d;

    ddr2_ref_timer #(
        .TREFI_CYC (TREFI_CYC),
        .MAX_PEND  (MAX_PEND)
    ) u_ref_timer (
        .ck             (ck),
        .rst_n          (rst_n),
        .en_i           (state_q != ST_INIT),
        .aref_end_i     (aref_end && (state_q == ST_AREF)),
        .ref_pending_o  (ref_pending),
        .ref_overflow_o (ref_overflow)
    );

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        case (state_q)
            ST_INIT: begin
                if (init_end) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (ref_pending) begin
                    state_d = ST_AREF;
                end else if (wr_req && rd_req) begin
                    state_d = last_wr_q ? ST_READ : ST_WRITE;
                end else if (wr_req) begin
                    state_d = ST_WRITE;
                end else if (rd_req) begin
                    state_d = ST_READ;
                end
            end
            ST_AREF: begin
                if (aref_end) state_d = ST_IDLE;
            end
            ST_WRITE: begin
                if (wr_end) begin
                    state_d   = ST_IDLE;
                    last_wr_d = 1'b1;
                end
            end
            ST_READ: begin
                if (rd_end) begin
                    state_d   = ST_IDLE;
                    last_wr_d = 1'b0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        aref_en = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        cke_d   = 1'b1;
        cmd_d   = CMD_NOP;
        ba_d    = '0;
        addr_d  = '0;
        case (state_q)
            ST_INIT: begin
                cke_d  = init_cke;
                cmd_d  = init_cmd;
                ba_d   = init_ba;
                addr_d = init_addr;
            end
            ST_AREF: begin
                aref_en = 1'b1;
                cmd_d   = aref_cmd;
                ba_d    = aref_ba;
                addr_d  = aref_addr;
            end
            ST_WRITE: begin
                wr_en  = 1'b1;
                cmd_d  = wr_cmd;
                ba_d   = wr_ba;
                addr_d = wr_addr;
            end
            ST_READ: begin
                rd_en  = 1'b1;
                cmd_d  = rd_cmd;
                ba_d   = rd_ba;
                addr_d = rd_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            ddr2_cke  <= 1'b0;
            ddr2_cmd  <= CMD_NOP;
            ddr2_ba   <= '0;
            ddr2_addr <= '0;
        end else begin
            ddr2_cke  <= cke_d;
            ddr2_cmd  <= cmd_d;
            ddr2_ba   <= ba_d;
            ddr2_addr <= addr_d;
        end
    end

endmodule

// File: doc/ddr2_arbiter.md
Name: ddr2_arbiter

Overview:
- Command-bus owner for the DDR2 controller. Passes the power-up init sequencer through until init completes, then grants the bus to exactly one of three requesters: auto-refresh, write, read.
- Contains the tREFI refresh timer and the postponed-refresh counter.
- Drives the registered CKE/BA/CMD/ADDR toward the PHY.

Parameters:
- BA_BITS, 3, bank address width
- ADDR_BITS, 14, row/column address width
- TREFI_CYC, 3120, refresh interval in ck cycles (7.8 us at tCK 2.5 ns)
- MAX_PEND, 8, maximum postponed refreshes (DDR2 limit)

Ports:
- ck  in  1  controller clock
- rst_n  in  1  asynchronous, active-low reset
- init_end  in  1  level; init sequence complete
- init_cke  in  1  CKE from init sequencer
- init_ba  in  BA_BITS  init bank address
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
- init_addr  in  ADDR_BITS  init address
- aref_en  out  1  refresh grant (level)
- aref_end  in  1  refresh engine finished (1-cycle pulse)
- aref_cmd, aref_ba, aref_addr  in  4/BA_BITS/ADDR_BITS  refresh engine bus
- wr_req  in  1  write request (level, held until granted)
- wr_en  out  1  write grant (level)
- wr_end  in  1  write burst finished (1-cycle pulse)
- wr_cmd, wr_ba, wr_addr  in  4/BA_BITS/ADDR_BITS  write engine bus
- rd_req, rd_en, rd_end, rd_cmd, rd_ba, rd_addr  as write, for read
- ddr2_cke  out  1  registered CKE
- ddr2_cmd  out  4  registered command
- ddr2_ba  out  BA_BITS  registered bank
- ddr2_addr  out  ADDR_BITS  registered address
- ref_overflow  out  1  sticky; pending refreshes saturated

Behaviour:
- Reset values:
  - state INIT; aref_en = wr_en = rd_en = 0
  - ddr2_cke = 0, ddr2_cmd = NOP (4'b0111), ddr2_ba = 0, ddr2_addr = 0
  - timer = 0, pend = 0, ref_overflow = 0, last_wr = 0
- States: INIT, IDLE, AREF, WRITE, READ.
- INIT
  - init_* are forwarded; all grants are 0; wr_req and rd_req are ignored.
  - When init_end = 1, go to IDLE on the next edge.
- IDLE
  - Bus outputs: cke = 1, cmd = NOP, ba = 0, addr = 0.
  - Arbitration, evaluated each cycle in this priority order:
    1. pend > 0 -> AREF.
    2. Only wr_req -> WRITE; only rd_req -> READ.
    3. Both wr_req and rd_req -> serve the one not served last: last_wr = 1 -> READ, else WRITE.
  - The grant is registered: it rises on the same edge the state is entered, so it is first visible one cycle after the winning request is sampled in IDLE.
- AREF / WRITE / READ
  - The granted engine's cmd/ba/addr are forwarded and cke = 1.
  - The grant is held until the engine's *_end pulse.
  - On that edge: state goes to IDLE and the grant drops.
  - last_wr updates on WRITE/READ exit (1 after WRITE, 0 after READ).
- No preemption: a refresh that comes due during WRITE or READ waits for that engine's *_end.
- At most one grant is high in any cycle.
- *_end for a non-granted engine is ignored.
- Output latency: ddr2_* = selected source registered, exactly 1 cycle after that source's value.
- Refresh timer
  - Counts only when state != INIT.
  - Runs 0..TREFI_CYC-1 and wraps to 0.
  - Produces an expiry pulse when the count is TREFI_CYC-1.
- Pending counter pend (width clog2(MAX_PEND)+1):
  - expiry & !aref_end -> +1
  - aref_end & !expiry -> -1
  - both in the same cycle -> unchanged
  - expiry with pend == MAX_PEND -> stays at MAX_PEND, ref_overflow set to 1
- ref_overflow clears only on reset.
- Reset asserted mid-operation: everything returns to reset values asynchronously, including timer, pend and grants; the bus outputs go to NOP with cke = 0.

Decomposition:
- Shared package / define.v:
  - command encodings NOP 0111, PRE 0010, AREF 0001, LM 0000, ACT 0011, WR 0100, RD 0101
  - BA_BITS, ADDR_BITS, tCK, tREFI
  - state encoding for INIT/IDLE/AREF/WRITE/READ
- One sub-module: ddr2_ref_timer.
  - Contains the interval counter, pend counter and ref_overflow.
  - Interface: enable, aref_end -> ref_pending, ref_overflow.

Test Plan (TREFI_CYC = 100, MAX_PEND = 8):
- Reset, init_cmd toggles PRE then LM, init_end rises at cycle 50 -> ddr2_cmd mirrors init_cmd 1 cycle late; no grant before cycle 51; state IDLE at 51 with cmd NOP, cke = 1.
- After init, hold wr_req = 1 and rd_req = 1, each engine pulses *_end 10 cycles after its grant -> grants alternate WRITE, READ, WRITE, READ; never two grants high; ddr2_cmd tracks the granted engine's cmd +1 cycle.
- Timer expires (100 cycles after init_end) during an active WRITE -> wr_en stays high until wr_end; aref_en rises the cycle after wr_en falls, even though rd_req is high.
- Hold aref_end low for 900 cycles -> pend reaches 8 at the 8th expiry; ref_overflow = 1 at the 9th expiry; pend stays 8; 8 aref_end pulses return pend to 0.
- Expiry and aref_end in the same cycle with pend = 1 -> pend remains 1; AREF re-entered after IDLE.
- Assert rst_n = 0 during READ -> rd_en, ddr2_cke and pend go to 0 immediately; ddr2_cmd = NOP; after release, wr_req is ignored until init_end.
